// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: button synchronise/debounce, mode FSM,
// centisecond tick prescaler and registered datapath control outputs.
module stopwatch_ctrl #(
  parameter int TICK_DIV = 100000,
  parameter int DB_LEN   = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pb_start,
  input  logic       pb_lap,
  input  logic       cnt_full,
  output logic       tick,
  output logic       cnt_clr,
  output logic       disp_hold,
  output logic       time_done,
  output logic [2:0] state
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int DW = $clog2(DB_LEN + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    LAP   = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Bit 0 is the start/stop button, bit 1 the lap/clear button.
  logic [1:0]          sync1, sync2, stable, stable_q, ev;
  logic [1:0][DW-1:0]  db_cnt;

  state_t         cur, nxt;
  logic [PW-1:0]  presc, presc_nxt;
  logic           counting, wrap, tick_nxt;
  logic           start_ev, lap_ev;

  // A level is accepted only after it differs from the stable level for an
  // unbroken run of samples; any return to the stable level restarts the run.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1    <= '0;
      sync2    <= '0;
      stable   <= '0;
      stable_q <= '0;
      ev       <= '0;
      db_cnt   <= '0;
    end else begin
      sync1    <= {pb_lap, pb_start};
      sync2    <= sync1;
      stable_q <= stable;
      ev       <= stable & ~stable_q;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DW'(DB_LEN)) begin
          stable[i] <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign start_ev = ev[0];
  assign lap_ev   = ev[1];

  // Saturation outranks start, which outranks lap; codes 5-7 behave as IDLE.
  always_comb begin
    counting  = (cur == RUN) || (cur == LAP);
    wrap      = counting && (presc == PW'(TICK_DIV - 1));
    nxt       = cur;
    presc_nxt = presc;
    tick_nxt  = 1'b0;

    case (cur)
      RUN: begin
        if (wrap && cnt_full) nxt = DONE;
        else if (start_ev)    nxt = PAUSE;
        else if (lap_ev)      nxt = LAP;
      end
      LAP: begin
        if (wrap && cnt_full) nxt = DONE;
        else if (start_ev)    nxt = PAUSE;
        else if (lap_ev)      nxt = RUN;
      end
      PAUSE: begin
        if (start_ev)         nxt = RUN;
        else if (lap_ev)      nxt = IDLE;
      end
      DONE: begin
        if (lap_ev)           nxt = IDLE;
      end
      default: begin
        if (start_ev)         nxt = RUN;
        else                  nxt = IDLE;
      end
    endcase

    if (counting)           presc_nxt = wrap ? '0 : presc + 1'b1;
    else if (cur != PAUSE)  presc_nxt = '0;

    // A wrap on the same edge that leaves RUN/LAP is not forwarded as a tick.
    tick_nxt = wrap && ((nxt == RUN) || (nxt == LAP));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur       <= IDLE;
      presc     <= '0;
      tick      <= 1'b0;
      cnt_clr   <= 1'b1;
      disp_hold <= 1'b0;
      time_done <= 1'b0;
    end else begin
      cur       <= nxt;
      presc     <= presc_nxt;
      tick      <= tick_nxt;
      cnt_clr   <= (nxt == IDLE);
      disp_hold <= (nxt == LAP);
      time_done <= (nxt == DONE);
    end
  end

  assign state = cur;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl (TICK_DIV=4, DB_LEN=3) with an expected-output
// scoreboard queue filled when stimulus is applied and drained at each check point.
module tb_stopwatch_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       pb_start, pb_lap, cnt_full;
  logic       tick, cnt_clr, disp_hold, time_done;
  logic [2:0] state;

  typedef struct packed {
    logic       tick;
    logic       clr;
    logic       hold;
    logic       done;
    logic [2:0] state;
  } vec_t;

  vec_t  exp_q[$];
  string tag_q[$];
  int    assertions = 0;
  int    failures   = 0;
  int    tick_count = 0;
  int    dbl_tick   = 0;
  logic  prev_tick  = 1'b0;
  int    t0;

  stopwatch_ctrl #(.TICK_DIV(4), .DB_LEN(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .pb_start  (pb_start),
    .pb_lap    (pb_lap),
    .cnt_full  (cnt_full),
    .tick      (tick),
    .cnt_clr   (cnt_clr),
    .disp_hold (disp_hold),
    .time_done (time_done),
    .state     (state)
  );

  always #5 clk = ~clk;

  function automatic vec_t vec(logic t, logic c, logic h, logic d, logic [2:0] s);
    vec_t v;
    v.tick = t; v.clr = c; v.hold = h; v.done = d; v.state = s;
    return v;
  endfunction

  // Advances n rising edges, sampling outputs on each following falling edge.
  task automatic cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      if (tick === 1'b1) tick_count++;
      if (tick === 1'b1 && prev_tick === 1'b1) dbl_tick++;
      prev_tick = tick;
    end
  endtask

  task automatic checkOutput();
    vec_t  obs, e;
    string tag;
    obs = {tick, cnt_clr, disp_hold, time_done, state};
    assertions++;
    if (exp_q.size() == 0) begin
      failures++;
      $error("[TB] FAIL scoreboard_empty observed=%b required=entry", obs);
    end else begin
      e   = exp_q.pop_front();
      tag = tag_q.pop_front();
      assert (obs === e) else begin
        failures++;
        $error("[TB] FAIL %s observed tick/clr/hold/done/state=%b_%b_%b_%b_%0d required=%b_%b_%b_%b_%0d",
               tag, obs.tick, obs.clr, obs.hold, obs.done, obs.state,
               e.tick, e.clr, e.hold, e.done, e.state);
      end
    end
  endtask

  task automatic applyStimulus(input logic s, input logic l, input logic f, input logic r,
                               input int n, input string tag, input vec_t e);
    pb_start = s;
    pb_lap   = l;
    cnt_full = f;
    rst      = r;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    cycles(n);
    checkOutput();
  endtask

  task automatic checkCount(input string tag, input int got, input int want);
    assertions++;
    assert (got === want) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d required=%0d", tag, got, want);
    end
  endtask

  initial begin
    vec_t vi, vr, vl, vp, vd;
    vi = vec(0, 1, 0, 0, 3'd0);
    vr = vec(0, 0, 0, 0, 3'd1);
    vl = vec(0, 0, 1, 0, 3'd2);
    vp = vec(0, 0, 0, 0, 3'd3);
    vd = vec(0, 0, 0, 1, 3'd4);

    applyStimulus(0, 0, 0, 1, 2, "reset", vi);
    for (int i = 0; i < 10; i++) applyStimulus(0, 0, 0, 0, 1, "idle_hold", vi);

    // Start press: event pulse at N+6, RUN visible after edge N+7.
    applyStimulus(1, 0, 0, 0, 7, "start_debounce_wait", vi);
    applyStimulus(1, 0, 0, 0, 1, "start_to_run", vr);
    t0 = tick_count;
    applyStimulus(1, 0, 0, 0, 2, "run_held", vr);
    applyStimulus(0, 0, 0, 0, 20, "start_release", vr);
    checkCount("run_ticks", tick_count - t0, 5);

    // Lap view and back.
    applyStimulus(0, 1, 0, 0, 7, "lap_wait", vr);
    applyStimulus(0, 1, 0, 0, 1, "lap_enter", vl);
    t0 = tick_count;
    applyStimulus(0, 0, 0, 0, 12, "lap_count", vl);
    checkCount("lap_ticks", tick_count - t0, 3);
    applyStimulus(0, 1, 0, 0, 7, "lap2_wait", vl);
    applyStimulus(0, 1, 0, 0, 1, "lap_exit", vr);
    applyStimulus(0, 0, 0, 0, 8, "run_before_pause", vr);

    // Pause lands with the prescaler at 2; resume must tick after two edges.
    t0 = tick_count;
    applyStimulus(1, 0, 0, 0, 7, "pause_wait", vr);
    applyStimulus(1, 0, 0, 0, 1, "pause_enter", vp);
    checkCount("ticks_before_pause", tick_count - t0, 2);
    t0 = tick_count;
    applyStimulus(0, 0, 0, 0, 20, "pause_hold", vp);
    applyStimulus(1, 0, 0, 0, 7, "resume_wait", vp);
    applyStimulus(1, 0, 0, 0, 1, "resume_run", vr);
    checkCount("pause_no_ticks", tick_count - t0, 0);
    applyStimulus(0, 0, 0, 0, 1, "resume_1", vr);
    applyStimulus(0, 0, 0, 0, 1, "resume_tick", vec(1, 0, 0, 0, 3'd1));

    applyStimulus(0, 0, 0, 0, 6, "run_gap", vr);
    applyStimulus(1, 0, 0, 0, 8, "pause2", vp);
    applyStimulus(0, 0, 0, 0, 6, "pause2_hold", vp);
    applyStimulus(0, 1, 0, 0, 7, "clear_wait", vp);
    applyStimulus(0, 1, 0, 0, 1, "clear_idle", vi);
    applyStimulus(0, 0, 0, 0, 6, "idle_after_clear", vi);

    // Saturation at the first wrap with cnt_full high.
    applyStimulus(1, 0, 0, 0, 8, "sat_run", vr);
    t0 = tick_count;
    applyStimulus(0, 0, 1, 0, 3, "sat_pre", vr);
    applyStimulus(0, 0, 1, 0, 1, "sat_done", vd);
    checkCount("sat_no_tick", tick_count - t0, 0);
    applyStimulus(0, 0, 1, 0, 6, "done_hold", vd);
    applyStimulus(1, 0, 1, 0, 8, "done_start_ignored", vd);
    applyStimulus(0, 0, 1, 0, 6, "done_release", vd);
    applyStimulus(0, 1, 1, 0, 7, "done_clear_wait", vd);
    applyStimulus(0, 1, 0, 0, 1, "done_clear", vi);
    applyStimulus(0, 0, 0, 0, 6, "idle_settle", vi);

    // Bouncing start button never produces an event.
    for (int i = 0; i < 20; i++) applyStimulus((i % 2) == 0, 0, 0, 0, 1, "bounce", vi);
    applyStimulus(0, 0, 0, 0, 8, "bounce_settle", vi);

    // Simultaneous start and lap events: start wins.
    applyStimulus(1, 0, 0, 0, 8, "sim_run", vr);
    applyStimulus(0, 0, 0, 0, 6, "sim_gap", vr);
    applyStimulus(1, 1, 0, 0, 8, "sim_both", vp);
    applyStimulus(0, 0, 0, 0, 6, "sim_release", vp);

    // Reset one edge before a due tick, then a button held through reset release.
    applyStimulus(1, 0, 0, 0, 8, "rst_run", vr);
    applyStimulus(0, 0, 0, 0, 1, "rst_pre", vr);
    applyStimulus(0, 0, 0, 1, 1, "rst_mid", vi);
    applyStimulus(1, 0, 0, 1, 2, "rst_held", vi);
    applyStimulus(1, 0, 0, 0, 7, "held_wait", vi);
    applyStimulus(1, 0, 0, 0, 1, "held_event", vr);
    applyStimulus(0, 0, 0, 0, 3, "final", vr);

    checkCount("no_double_tick", dbl_tick, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
